acc_cpu_gen2: RTL and testbench

//  Parametrised accumulator CPU; next generation of the 4-bit accumulator core.

---
 rtl/acc_cpu_gen2.sv | 189 ++++++++++++++++++
 tb/tb_acc_cpu_gen2.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_gen2.sv
// Parametrised accumulator CPU: A/B registers, data memory, LIFO data stack, ZF/CF/SF flags.
// Optional saturating ADDI/SUBI arithmetic when the CPU_SAT_EN macro is defined.
module acc_cpu_gen2 #(
  parameter int DW        = 4,
  parameter int AW        = 4,
  parameter int PW        = 4,
  parameter int STK_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [DW+3:0] opcode,
  output logic [PW-1:0] pc,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          ZF,
  output logic          CF,
  output logic          SF,
  output logic          stk_err,
  output logic          halt
);

  localparam int SPW = $clog2(STK_DEPTH) + 1;

  localparam logic [3:0] OP_ADDI = 4'h0, OP_SUBI = 4'h1, OP_SWAP = 4'h2, OP_LDA  = 4'h3;
  localparam logic [3:0] OP_STB  = 4'h4, OP_OUT  = 4'h5, OP_ANDI = 4'h6, OP_ORM  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8, OP_JMP  = 4'h9, OP_IN   = 4'hA, OP_PUSH = 4'hB;
  localparam logic [3:0] OP_POP  = 4'hC, OP_LDB  = 4'hD, OP_CLR  = 4'hE, OP_HLT  = 4'hF;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t          state_r, state_n;
  logic [DW-1:0]   a_r, a_n, b_r, b_n, dout_r, dout_n;
  logic [PW-1:0]   pc_r, pc_n;
  logic            zf_r, zf_n, cf_r, cf_n, sf_r, sf_n;
  logic            ov_r, ov_n, serr_r, serr_n;
  logic [SPW-1:0]  sp_r, sp_n, sp_dec_s;
  logic [DW-1:0]   dmem_r [2**AW];
  logic [DW-1:0]   stk_r  [STK_DEPTH];

  logic            ready_s, halt_s, accept_s, wr_a_s, full_s, empty_s;
  logic [3:0]      op_s;
  logic [DW-1:0]   imm_s;
  logic [AW-1:0]   addr_s;
  logic [PW-1:0]   tgt_s;
  logic [DW:0]     add_s, sub_s;

  assign op_s     = opcode[DW+3:DW];
  assign imm_s    = opcode[DW-1:0];
  assign addr_s   = imm_s[AW-1:0];
  assign tgt_s    = imm_s[PW-1:0];
  assign accept_s = op_valid & ready_s;
  assign add_s    = {1'b0, a_r} + {1'b0, imm_s};
  assign sub_s    = {1'b0, a_r} - {1'b0, imm_s};
  assign full_s   = (sp_r == SPW'(STK_DEPTH));
  assign empty_s  = (sp_r == {SPW{1'b0}});
  assign sp_dec_s = sp_r - SPW'(1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state: HLT parks the core until reset
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s && (op_s == OP_HLT)) state_n = ST_HALT;
        else                              state_n = ST_RUN;
      end
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_RUN;
    endcase
  end

  // State decode
  always_comb begin
    ready_s = 1'b0;
    halt_s  = 1'b0;
    case (state_r)
      ST_RUN:  ready_s = 1'b1;
      ST_HALT: halt_s  = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // Instruction execute: next architectural state for the accepted op
  always_comb begin
    a_n = a_r;  b_n = b_r;  dout_n = dout_r;  pc_n = pc_r;
    zf_n = zf_r;  cf_n = cf_r;  sf_n = sf_r;
    ov_n = 1'b0;  serr_n = serr_r;  sp_n = sp_r;  wr_a_s = 1'b0;
    if (accept_s) begin
      pc_n = pc_r + PW'(1);
      case (op_s)
        OP_ADDI: begin
          wr_a_s = 1'b1;
          cf_n   = add_s[DW];
`ifdef CPU_SAT_EN
          a_n    = add_s[DW] ? {DW{1'b1}} : add_s[DW-1:0];
`else
          a_n    = add_s[DW-1:0];
`endif
        end
        OP_SUBI: begin
          wr_a_s = 1'b1;
          cf_n   = sub_s[DW];
`ifdef CPU_SAT_EN
          a_n    = sub_s[DW] ? {DW{1'b0}} : sub_s[DW-1:0];
`else
          a_n    = sub_s[DW-1:0];
`endif
        end
        OP_SWAP: begin a_n = b_r; b_n = a_r; wr_a_s = 1'b1; end
        OP_LDA:  begin a_n = dmem_r[addr_s]; wr_a_s = 1'b1; end
        OP_STB:  b_n = b_r;
        OP_OUT:  begin dout_n = a_r; ov_n = 1'b1; end
        OP_ANDI: begin a_n = a_r & imm_s; wr_a_s = 1'b1; end
        OP_ORM:  b_n = b_r | dmem_r[addr_s];
        OP_JZ: begin
          if (zf_r) pc_n = tgt_s;
          else      pc_n = pc_r + PW'(1);
        end
        OP_JMP:  pc_n = tgt_s;
        OP_IN:   begin a_n = data_in; wr_a_s = 1'b1; end
        OP_PUSH: begin
          if (full_s) serr_n = 1'b1;
          else begin sp_n = sp_r + SPW'(1); a_n = {DW{1'b0}}; wr_a_s = 1'b1; end
        end
        OP_POP: begin
          if (empty_s) serr_n = 1'b1;
          else begin sp_n = sp_dec_s; a_n = stk_r[sp_dec_s[SPW-2:0]]; wr_a_s = 1'b1; end
        end
        OP_LDB:  b_n = imm_s;
        OP_CLR:  begin sp_n = {SPW{1'b0}}; zf_n = 1'b0; cf_n = 1'b0; sf_n = 1'b0; serr_n = 1'b0; end
        OP_HLT:  pc_n = pc_r;
        default: pc_n = pc_r;
      endcase
      if (wr_a_s) begin
        zf_n = (a_n == {DW{1'b0}});
        sf_n = a_n[DW-1];
      end else begin
        wr_a_s = 1'b0;
      end
    end else begin
      pc_n = pc_r;
    end
  end

  // Architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r <= {DW{1'b0}};  b_r <= {DW{1'b0}};  dout_r <= {DW{1'b0}};  pc_r <= {PW{1'b0}};
      zf_r <= 1'b0;  cf_r <= 1'b0;  sf_r <= 1'b0;
      ov_r <= 1'b0;  serr_r <= 1'b0;  sp_r <= {SPW{1'b0}};
    end else begin
      a_r <= a_n;  b_r <= b_n;  dout_r <= dout_n;  pc_r <= pc_n;
      zf_r <= zf_n;  cf_r <= cf_n;  sf_r <= sf_n;
      ov_r <= ov_n;  serr_r <= serr_n;  sp_r <= sp_n;
    end
  end

  // Memory and stack writes; reset held low suppresses any in-flight write
  always_ff @(posedge clk) begin
    if (reset && accept_s && (op_s == OP_STB)) dmem_r[addr_s] <= b_r;
    if (reset && accept_s && (op_s == OP_PUSH) && !full_s) stk_r[sp_r[SPW-2:0]] <= a_r;
  end

  assign op_ready  = ready_s;
  assign halt      = halt_s;
  assign pc        = pc_r;
  assign data_out  = dout_r;
  assign out_valid = ov_r;
  assign A         = a_r;
  assign B         = b_r;
  assign ZF        = zf_r;
  assign CF        = cf_r;
  assign SF        = sf_r;
  assign stk_err   = serr_r;

endmodule

// File: tb/tb_acc_cpu_gen2.sv
// Scoreboard bench for acc_cpu_gen2 (DW=AW=PW=4, STK_DEPTH=16): issued ops push expected state,
// a negedge monitor pops and compares one entry per accepted op.
module tb_acc_cpu_gen2;

  localparam logic [3:0] ADDI = 4'h0, SUBI = 4'h1, SWAP = 4'h2, LDA  = 4'h3;
  localparam logic [3:0] STB  = 4'h4, OUT  = 4'h5, ANDI = 4'h6, ORM  = 4'h7;
  localparam logic [3:0] JZ   = 4'h8, JMP  = 4'h9, IN   = 4'hA, PUSH = 4'hB;
  localparam logic [3:0] POP  = 4'hC, LDB  = 4'hD, CLR  = 4'hE, HLT  = 4'hF;

  logic       clk = 1'b0;
  logic       reset, op_valid, op_ready, out_valid;
  logic [7:0] opcode;
  logic [3:0] pc, data_in, data_out, A, B;
  logic       ZF, CF, SF, stk_err, halt;

  acc_cpu_gen2 #(.DW(4), .AW(4), .PW(4), .STK_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .pc(pc), .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
    .A(A), .B(B), .ZF(ZF), .CF(CF), .SF(SF), .stk_err(stk_err), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b, p, d;
    logic       z, c, s, e, ov, h;
  } exp_t;

  exp_t q[$];
  exp_t x;
  int   total = 0;
  int   bad   = 0;
  int   npc   = 0;
  bit   pend  = 1'b0;
  int   a2, s2, a13, z13, s13, pc14, v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic int nx();
    npc = (npc + 1) % 16;
    return npc;
  endfunction

  task automatic iss(input logic [3:0] op, input logic [3:0] imm,
                     input int a, input int b, input int z, input int c, input int s,
                     input int p, input int e, input int ov, input int d, input int h);
    exp_t y;
    @(posedge clk); #1;
    op_valid = 1'b1;
    opcode   = {op, imm};
    y.a = a[3:0]; y.b = b[3:0]; y.z = z[0]; y.c = c[0]; y.s = s[0];
    y.p = p[3:0]; y.e = e[0]; y.ov = ov[0]; y.d = d[3:0]; y.h = h[0];
    q.push_back(y);
  endtask

  // Monitor: compare the op accepted in the previous cycle, then note this cycle's handshake
  always @(negedge clk) begin
    if (pend) begin
      if (q.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        x = q.pop_front();
        chk("A", A, x.a);          chk("B", B, x.b);
        chk("ZF", ZF, x.z);        chk("CF", CF, x.c);        chk("SF", SF, x.s);
        chk("pc", pc, x.p);        chk("stk_err", stk_err, x.e);
        chk("out_valid", out_valid, x.ov);
        chk("data_out", data_out, x.d);
        chk("halt", halt, x.h);
      end
    end
    pend = op_valid && op_ready && reset;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_A"}, A, 32'd0);          chk({tag, "_B"}, B, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);        chk({tag, "_dout"}, data_out, 32'd0);
    chk({tag, "_ov"}, out_valid, 32'd0); chk({tag, "_flags"}, {ZF, CF, SF}, 32'd0);
    chk({tag, "_serr"}, stk_err, 32'd0); chk({tag, "_halt"}, halt, 32'd0);
    chk({tag, "_ready"}, op_ready, 32'd1);
  endtask

  initial begin
`ifdef CPU_SAT_EN
    a2 = 15; s2 = 1; a13 = 0;  z13 = 1; s13 = 0; pc14 = 7;
`else
    a2 = 1;  s2 = 0; a13 = 15; z13 = 0; s13 = 1; pc14 = 0;
`endif
    reset = 1'b0; op_valid = 1'b0; opcode = 8'h00; data_in = 4'd6;
    #12;
    chk_reset("rst");
    @(posedge clk); #1;
    reset = 1'b1;

    // arithmetic, carry, memory, output
    iss(ADDI, 4'd9,  9,  0,  0, 0, 1,  nx(), 0, 0, 0, 0);
    iss(ADDI, 4'd8,  a2, 0,  0, 1, s2, nx(), 0, 0, 0, 0);
    iss(LDB,  4'd5,  a2, 5,  0, 1, s2, nx(), 0, 0, 0, 0);
    iss(STB,  4'd3,  a2, 5,  0, 1, s2, nx(), 0, 0, 0, 0);
    iss(LDA,  4'd3,  5,  5,  0, 1, 0,  nx(), 0, 0, 0, 0);
    iss(OUT,  4'd0,  5,  5,  0, 1, 0,  nx(), 0, 1, 5, 0);
    iss(ANDI, 4'd4,  4,  5,  0, 1, 0,  nx(), 0, 0, 5, 0);
    iss(LDB,  4'd10, 4,  10, 0, 1, 0,  nx(), 0, 0, 5, 0);
    iss(ORM,  4'd3,  4,  15, 0, 1, 0,  nx(), 0, 0, 5, 0);
    iss(SWAP, 4'd0,  15, 4,  0, 1, 1,  nx(), 0, 0, 5, 0);
    iss(SUBI, 4'd15, 0,  4,  1, 0, 0,  nx(), 0, 0, 5, 0);
    // jumps: taken JZ, borrow, untaken JZ wrapping pc 15 -> 0, JMP
    npc = 14;
    iss(JZ,   4'd14, 0,   4, 1,   0, 0,   npc,  0, 0, 5, 0);
    iss(SUBI, 4'd1,  a13, 4, z13, 1, s13, nx(), 0, 0, 5, 0);
    npc = pc14;
    iss(JZ,   4'd7,  a13, 4, z13, 1, s13, npc,  0, 0, 5, 0);
    npc = 3;
    iss(JMP,  4'd3,  a13, 4, z13, 1, s13, npc,  0, 0, 5, 0);
    iss(IN,   4'd0,  6,   4, 0,   1, 0,   nx(), 0, 0, 5, 0);
    iss(CLR,  4'd0,  6,   4, 0,   0, 0,   nx(), 0, 0, 5, 0);
    iss(ANDI, 4'd0,  0,   4, 1,   0, 0,   nx(), 0, 0, 5, 0);
    // stack: fill with 1..15,0, overflow, drain LIFO, underflow, clear
    for (int k = 1; k <= 16; k++) begin
      v = k % 16;
      iss(ADDI, v[3:0], v, 4, (v == 0) ? 1 : 0, 0, (v >> 3) & 1, nx(), 0, 0, 5, 0);
      iss(PUSH, 4'd0,   0, 4, 1, 0, 0, nx(), 0, 0, 5, 0);
    end
    iss(ADDI, 4'd9, 9, 4, 0, 0, 1, nx(), 0, 0, 5, 0);
    iss(PUSH, 4'd0, 9, 4, 0, 0, 1, nx(), 1, 0, 5, 0);
    for (int k = 16; k >= 1; k--) begin
      v = k % 16;
      iss(POP, 4'd0, v, 4, (v == 0) ? 1 : 0, 0, (v >> 3) & 1, nx(), 1, 0, 5, 0);
    end
    iss(POP, 4'd0, 1, 4, 0, 0, 0, nx(), 1, 0, 5, 0);
    iss(CLR, 4'd0, 1, 4, 0, 0, 0, nx(), 0, 0, 5, 0);
    iss(HLT, 4'd0, 1, 4, 0, 0, 0, npc,  0, 0, 5, 1);

    // halted core ignores further ops
    @(posedge clk); #1;
    opcode = {ADDI, 4'd1};
    repeat (3) @(posedge clk);
    #1;
    chk("halt_pc", pc, npc);
    chk("halt_ready", op_ready, 32'd0);
    chk("halt_flag", halt, 32'd1);
    chk("halt_A", A, 32'd1);

    // async reset mid-cycle with a pending STB that must not write
    opcode = {STB, 4'd3};
    #3 reset = 1'b0;
    #1 chk_reset("arst");
    @(posedge clk); #1;
    reset = 1'b1;
    op_valid = 1'b0;
    npc = 0;
    iss(LDA, 4'd3, 5, 0, 0, 0, 0, nx(), 0, 0, 0, 0);
    iss(OUT, 4'd0, 5, 0, 0, 0, 0, nx(), 0, 1, 5, 0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drain", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
